// File: rtl/key_shift_reg_if.sv
// Command/data bundle for the lockable key register: command inputs toward the
// register, key contents and status back from it.
interface key_shift_reg_if #(
   parameter int WIDTH = 64
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             EN;
   logic [1:0]       MODE;
   logic [WIDTH-1:0] D;
   logic             SI;
   logic [WIDTH-1:0] Q;
   logic             SO;
   logic [CW-1:0]    CNT;
   logic             FULL;
   logic             LOCKED;

   modport master (
      output EN, MODE, D, SI,
      input  Q, SO, CNT, FULL, LOCKED
   );

   modport slave (
      input  EN, MODE, D, SI,
      output Q, SO, CNT, FULL, LOCKED
   );
endinterface

// File: rtl/key_shift_reg.sv
// Lockable activation-key register: parallel load, serial scan in/out and a
// one-way lock that freezes the key and blanks scan-out until reset.
//
// state     | meaning
// ----------|--------------------------------------------------------------
// ST_OPEN   | commands accepted; CNT tracks EMPTY / FILLING / FULL
// ST_LOCKED | key frozen, all commands ignored, SO forced low; only R exits
module key_shift_reg #(
   parameter int               WIDTH    = 64,
   parameter logic [WIDTH-1:0] INIT     = '0,
   parameter bit               LOCKABLE = 1'b1
) (
   input logic            C,
   input logic            R,
   key_shift_reg_if.slave bus
);
   localparam int            CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   localparam logic [1:0] MODE_LOAD  = 2'b01;
   localparam logic [1:0] MODE_SHIFT = 2'b10;
   localparam logic [1:0] MODE_LOCK  = 2'b11;

   typedef enum logic {
      ST_OPEN,
      ST_LOCKED
   } lock_state_t;

   lock_state_t      state, state_nxt;
   logic [WIDTH-1:0] key, key_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             full;

   assign full = (cnt == CNT_MAX);

   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         state <= ST_OPEN;
         key   <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         key   <= key_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      key_nxt   = key;
      cnt_nxt   = cnt;
      if (state == ST_OPEN && bus.EN) begin
         case (bus.MODE)
            MODE_LOAD: begin
               key_nxt = bus.D;
               cnt_nxt = CNT_MAX;
            end
            MODE_SHIFT: begin
               key_nxt = {bus.SI, key[WIDTH-1:1]};
               // Saturate so a post-load scan-out check keeps the register FULL
               if (cnt != CNT_MAX) cnt_nxt = cnt + CW'(1);
            end
            MODE_LOCK: begin
               if (LOCKABLE && full) state_nxt = ST_LOCKED;
            end
            default: ;
         endcase
      end
   end

   assign bus.Q      = key;
   assign bus.CNT    = cnt;
   assign bus.FULL   = full;
   assign bus.LOCKED = (state == ST_LOCKED);
   assign bus.SO     = (state == ST_LOCKED) ? 1'b0 : key[0];
endmodule

// File: tb/tb_key_shift_reg.sv
// Scoreboard bench for key_shift_reg: a lockable and a non-lockable 8-bit
// instance checked against a behavioural key-register model.
module tb_key_shift_reg;
   logic C = 1'b0;
   logic R = 1'b0;
   logic sel = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] m_q;
   int         m_cnt;
   logic       m_locked;

   typedef struct {
      logic [7:0] q;
      logic [3:0] cnt;
      logic       full;
      logic       locked;
      logic       so;
   } exp_t;

   exp_t sb[$];

   key_shift_reg_if #(.WIDTH(8)) b0 ();
   key_shift_reg_if #(.WIDTH(8)) b1 ();

   key_shift_reg #(.WIDTH(8), .INIT(8'hA5), .LOCKABLE(1'b1)) dut (
      .C(C), .R(R), .bus(b0.slave)
   );

   key_shift_reg #(.WIDTH(8), .INIT(8'hA5), .LOCKABLE(1'b0)) dut_nl (
      .C(C), .R(R), .bus(b1.slave)
   );

   always #5 C = ~C;

   wire [7:0] o_q      = sel ? b1.Q      : b0.Q;
   wire [3:0] o_cnt    = sel ? b1.CNT    : b0.CNT;
   wire       o_full   = sel ? b1.FULL   : b0.FULL;
   wire       o_locked = sel ? b1.LOCKED : b0.LOCKED;
   wire       o_so     = sel ? b1.SO     : b0.SO;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic en, input logic [1:0] mode, input logic [7:0] d,
                       input logic si, input string tag);
      exp_t e;
      if (!sel) begin
         b0.EN = en; b0.MODE = mode; b0.D = d; b0.SI = si;
         b1.EN = 1'b0;
      end else begin
         b1.EN = en; b1.MODE = mode; b1.D = d; b1.SI = si;
         b0.EN = 1'b0;
      end
      if (!m_locked && en) begin
         case (mode)
            2'b01: begin m_q = d; m_cnt = 8; end
            2'b10: begin m_q = {si, m_q[7:1]}; if (m_cnt < 8) m_cnt++; end
            2'b11: if (!sel && m_cnt == 8) m_locked = 1'b1;
            default: ;
         endcase
      end
      e.q      = m_q;
      e.cnt    = 4'(m_cnt);
      e.full   = (m_cnt == 8);
      e.locked = m_locked;
      e.so     = m_locked ? 1'b0 : m_q[0];
      sb.push_back(e);
      @(posedge C); #1;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_q"},      32'(o_q),      32'(e.q));
         check({tag, "_cnt"},    32'(o_cnt),    32'(e.cnt));
         check({tag, "_full"},   32'(o_full),   32'(e.full));
         check({tag, "_locked"}, 32'(o_locked), 32'(e.locked));
         check({tag, "_so"},     32'(o_so),     32'(e.so));
      end
   endtask

   task automatic pulse_reset(input string tag);
      #2 R = 1'b0;
      #1;
      check({tag, "_q"},      32'(o_q),      32'h A5);
      check({tag, "_cnt"},    32'(o_cnt),    32'd0);
      check({tag, "_full"},   32'(o_full),   32'd0);
      check({tag, "_locked"}, 32'(o_locked), 32'd0);
      check({tag, "_so"},     32'(o_so),     32'd1);
      m_q = 8'hA5; m_cnt = 0; m_locked = 1'b0;
      @(negedge C);
      R = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] fill_bits;
      logic [7:0] lo_bits;
      fill_bits = 8'b1001_0110;
      b0.EN = 0; b0.MODE = 0; b0.D = 0; b0.SI = 0;
      b1.EN = 0; b1.MODE = 0; b1.D = 0; b1.SI = 0;
      m_q = 8'hA5; m_cnt = 0; m_locked = 1'b0;

      repeat (2) @(posedge C);
      #1;
      check("por_q",   32'(o_q),   32'hA5);
      check("por_cnt", 32'(o_cnt), 32'd0);
      check("por_so",  32'(o_so),  32'd1);
      @(negedge C);
      R = 1'b1;

      // reset asserted mid-shift
      step(1, 2'b10, 8'h00, 1'b0, "pre0");
      step(1, 2'b10, 8'h00, 1'b1, "pre1");
      pulse_reset("rst_midshift");

      // serial fill: bits enter LSB-first order 0,1,1,0,1,0,0,1
      for (int i = 0; i < 8; i++) step(1, 2'b10, 8'h00, fill_bits[i], "fill");
      check("fill_q",    32'(o_q),    32'h96);
      check("fill_cnt",  32'(o_cnt),  32'd8);
      check("fill_full", 32'(o_full), 32'd1);
      check("fill_so",   32'(o_so),   32'd0);
      step(1, 2'b10, 8'h00, 1'b1, "shift9");
      check("shift9_q",   32'(o_q),   32'hCB);
      check("shift9_cnt", 32'(o_cnt), 32'd8);

      // early lock is ignored, lock right after completing shift succeeds
      pulse_reset("rst_early");
      for (int i = 0; i < 3; i++) step(1, 2'b10, 8'h00, fill_bits[i], "part");
      step(1, 2'b11, 8'h00, 1'b0, "early_lock");
      check("early_locked", 32'(o_locked), 32'd0);
      check("early_cnt",    32'(o_cnt),    32'd3);
      for (int i = 3; i < 8; i++) step(1, 2'b10, 8'h00, fill_bits[i], "rest");
      step(1, 2'b11, 8'h00, 1'b0, "lock");
      check("lock_locked", 32'(o_locked), 32'd1);
      check("lock_so",     32'(o_so),     32'd0);
      check("lock_q",      32'(o_q),      32'h96);

      // locked freeze
      pulse_reset("rst_locked");
      step(1, 2'b01, 8'h3C, 1'b0, "ld3c");
      step(1, 2'b11, 8'h00, 1'b0, "lk3c");
      step(1, 2'b01, 8'hFF, 1'b0, "frz_ld");
      for (int i = 0; i < 4; i++) step(1, 2'b10, 8'h00, 1'b1, "frz_sh");
      step(1, 2'b00, 8'h00, 1'b0, "frz_hold");
      check("frz_q",   32'(o_q),   32'h3C);
      check("frz_cnt", 32'(o_cnt), 32'd8);
      check("frz_so",  32'(o_so),  32'd0);
      pulse_reset("rst_frozen");

      // EN gating then load
      step(0, 2'b01, 8'h55, 1'b0, "en0_ld");
      step(0, 2'b10, 8'h00, 1'b1, "en0_sh");
      check("en0_q",   32'(o_q),   32'hA5);
      check("en0_cnt", 32'(o_cnt), 32'd0);
      step(1, 2'b01, 8'h55, 1'b0, "ld55");
      check("ld55_q",    32'(o_q),    32'h55);
      check("ld55_cnt",  32'(o_cnt),  32'd8);
      check("ld55_full", 32'(o_full), 32'd1);

      // load after partial shift discards the count, shift after load stays FULL
      pulse_reset("rst_part");
      step(1, 2'b10, 8'h00, 1'b1, "p1");
      step(1, 2'b10, 8'h00, 1'b1, "p2");
      step(1, 2'b01, 8'hC3, 1'b0, "pld");
      for (int i = 0; i < 3; i++) step(1, 2'b10, 8'h00, 1'($urandom_range(0, 1)), "scanout");

      // non-lockable instance: lock behaves as hold
      sel = 1'b1;
      pulse_reset("rst_nl");
      lo_bits = 8'($urandom);
      for (int i = 0; i < 8; i++) step(1, 2'b10, 8'h00, lo_bits[i], "nl_fill");
      step(1, 2'b11, 8'h00, 1'b0, "nl_lock");
      check("nl_locked", 32'(o_locked), 32'd0);
      check("nl_q",      32'(o_q),      32'(lo_bits));
      step(1, 2'b10, 8'h00, 1'b0, "nl_shift");
      check("nl_so", 32'(o_so), 32'(lo_bits[1]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/key_shift_reg.md
# key_shift_reg

Parametrised, lockable key register: the successor to the single-bit async-reset flip-flop cell, generalised to WIDTH bits. It supports parallel load, serial scan-in/scan-out and a one-way lock. It sits between the key-delivery path (serial scan or parallel bus) and the key inputs of locked netlists. It holds the activation key and, once locked, stops the key from being overwritten or scanned out until the next reset.

## Interface
Parameters:
- WIDTH, 64, key width in bits (≥ 2)
- INIT, {WIDTH{1'b0}}, value Q takes on reset
- LOCKABLE, 1, 1 enables the lock command; 0 makes MODE=11 behave as hold

Ports:
- C  in  1  clock, rising edge
- R  in  1  reset, asynchronous, active-low
- EN  in  1  command qualifier; MODE is ignored when EN=0
- MODE  in  2  00 hold, 01 parallel load, 10 shift, 11 lock
- D  in  WIDTH  parallel load data
- SI  in  1  serial input, enters at bit WIDTH-1
- Q  out  WIDTH  key register contents, drives key inputs
- SO  out  1  serial output
- CNT  out  $clog2(WIDTH+1)  bits accepted since reset, saturates at WIDTH
- FULL  out  1  CNT == WIDTH
- LOCKED  out  1  lock state

## Operation
- One clock (C); reset is asynchronous and active-low (R); all state is cleared on R low, independent of C.
- Reset values: Q=INIT, CNT=0, FULL=0, LOCKED=0, SO=INIT[0].
- States, encoded by CNT and LOCKED:
  - EMPTY: CNT=0
  - FILLING: 0<CNT<WIDTH
  - FULL: CNT=WIDTH, LOCKED=0
  - LOCKED: LOCKED=1
- Commands apply on the rising C edge with EN=1, only while LOCKED=0:
  - 00 hold: no change.
  - 01 load: Q←D; CNT←WIDTH. Valid from any unlocked state; goes to FULL.
  - 10 shift: Q←{SI, Q[WIDTH-1:1]}, so the LSB leaves first. CNT←min(CNT+1, WIDTH).
    - EMPTY→FILLING, or EMPTY→FULL when WIDTH=1 (excluded by WIDTH≥2).
    - FILLING→FULL on the WIDTH-th shift. FULL stays FULL.
  - 11 lock:
    - If LOCKABLE=1 and FULL: LOCKED←1, Q unchanged.
    - If not FULL: ignored; CNT and Q unchanged.
    - If LOCKABLE=0: hold.
- LOCKED is absorbing. All commands are ignored, Q and CNT are frozen, and only R clears it.
- SO = Q[0] when LOCKED=0, forced to 0 when LOCKED=1. This prevents key readout.
- FULL = (CNT==WIDTH), combinational from the CNT register.
- EN=0: every output holds regardless of MODE, D, SI.
- Width rules:
  - CNT never exceeds WIDTH and never wraps.
  - A load after partial shifting discards the partial count.
  - A shift after load keeps CNT=WIDTH while data moves. This allows scan-out verification before lock.

## Timing
- All state updates are registered: a command at edge k is visible on Q/CNT/FULL/LOCKED after edge k.
- Latency: 1 cycle for load, shift and lock. A full serial key takes exactly WIDTH shift cycles.
- SO is combinational from Q and LOCKED, so it is valid in the same cycle Q updates. It reads 0 starting in the cycle after the lock edge.
- R asserted mid-shift or while LOCKED: immediate return to reset values. R is deasserted synchronously to C by upstream logic.
- Back-to-back commands on consecutive edges are legal. A lock issued on the edge right after the completing shift succeeds, because FULL is already 1.

## Test plan
- Reset, WIDTH=8, INIT=8'hA5: drive R low mid-cycle -> Q=8'hA5, CNT=0, FULL=0, LOCKED=0, SO=1, all asynchronously.
- Serial fill: shift in 0,1,1,0,1,0,0,1 (EN=1, MODE=10) -> after 8 edges Q=8'h96, CNT=8, FULL=1, SO=0. A 9th shift with SI=1 -> Q=8'hCB, CNT stays 8.
- Early lock: after 3 shifts, issue MODE=11 -> LOCKED=0, CNT=3, Q unchanged. Finish 5 more shifts, then lock -> LOCKED=1, SO=0.
- Locked freeze: with LOCKED=1 and Q=8'h3C, apply load D=8'hFF, then 4 shifts, then hold -> Q=8'h3C, CNT=8, SO=0 throughout. Pulse R -> Q=INIT, LOCKED=0.
- Load/EN: EN=0 with MODE=01, D=8'h55 -> no change. EN=1 -> Q=8'h55, CNT=8, FULL=1 after one edge.
- LOCKABLE=0: fill, then MODE=11 -> LOCKED stays 0. A subsequent shift still moves data and SO follows Q[0].
